// File: rtl/uart_proto_pkg.sv
// Blackjack UART link protocol: frame tags, card width, decoder states.
// Shared by the link encoder and decoder so both agree on the byte layout.
package uart_proto_pkg;

   localparam int CARD_W = 4;

   localparam logic [3:0] TAG_STATUS = 4'd0;
   localparam logic [3:0] TAG_CARD0  = 4'd1;
   localparam logic [3:0] TAG_CARD1  = 4'd2;
   localparam logic [3:0] TAG_CARD2  = 4'd3;

   typedef logic [CARD_W-1:0] card_t;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      EXP1 = 2'd1,
      EXP2 = 2'd2,
      EXP3 = 2'd3
   } dec_state_t;

endpackage

// File: rtl/uart_decoder_if.sv
// Receiver FIFO read port: rx_empty, r_data (FWFT head byte), rd_uart pop.
// master = FIFO side, slave = consumer side.
interface uart_decoder_if;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;

   modport master (output rx_empty, output r_data, input rd_uart);
   modport slave  (input rx_empty, input r_data, output rd_uart);
endinterface

// File: rtl/uart_rx_timeout.sv
// Inter-byte idle counter. Ports: clk, rst_n, clr (sync clear), en (count),
// expired (threshold reached this cycle while enabled and not cleared).
module uart_rx_timeout #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   // A byte arriving on the threshold cycle clears instead of expiring.
   assign expired = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/uart_decoder.sv
// Parses 4-byte status/card frames from the RX FIFO, commits whole frames.
// Ports: clk, rst_n, rx (FIFO slave), deal/dealer_finished/cards, pulses, err_count.
module uart_decoder
   import uart_proto_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_decoder_if.slave rx,
   output logic          deal,
   output logic          dealer_finished,
   output card_t [2:0]   dealer_card_values,
   output logic          frame_valid,
   output logic          frame_err,
   output logic [7:0]    err_count
);

   dec_state_t state, state_d;

   logic       byte_v;
   logic [3:0] tag;
   logic [3:0] pay;
   logic       stat_ok, in_seq, card_hunt, bad_byte, tmo;
   logic       err_d, commit_d, ld_st, ld_c0, ld_c1;
   logic       sh_deal, sh_fin;
   card_t      sh_c0, sh_c1;

   // Every presented byte is popped and parsed in the same cycle.
   assign rx.rd_uart = ~rx.rx_empty;
   assign byte_v     = ~rx.rx_empty;
   assign tag        = rx.r_data[3:0];
   assign pay        = rx.r_data[7:4];

   assign stat_ok = byte_v && tag == TAG_STATUS && pay[3:2] == 2'b00;

   assign in_seq = byte_v &&
      ((state == EXP1 && tag == TAG_CARD0) ||
       (state == EXP2 && tag == TAG_CARD1) ||
       (state == EXP3 && tag == TAG_CARD2));

   // Stray cards while hunting are expected after reset/resync.
   assign card_hunt = byte_v && state == HUNT &&
      (tag == TAG_CARD0 || tag == TAG_CARD1 || tag == TAG_CARD2);

   assign bad_byte = byte_v & ~stat_ok & ~in_seq & ~card_hunt;

   uart_rx_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (byte_v | (state == HUNT)),
      .en      (state != HUNT),
      .expired (tmo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HUNT;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (1'b1)
         stat_ok:   state_d = EXP1;
         in_seq:    state_d = (state == EXP1) ? EXP2 :
                              (state == EXP2) ? EXP3 : HUNT;
         card_hunt: state_d = HUNT;
         bad_byte:  state_d = HUNT;
         tmo:       state_d = HUNT;
         default:   state_d = state;
      endcase
   end

   always_comb begin
      err_d    = bad_byte | tmo | (stat_ok & (state != HUNT));
      commit_d = in_seq & (state == EXP3);
      ld_st    = stat_ok;
      ld_c0    = in_seq & (state == EXP1);
      ld_c1    = in_seq & (state == EXP2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_deal <= 1'b0;
         sh_fin  <= 1'b0;
         sh_c0   <= '0;
         sh_c1   <= '0;
      end else begin
         if (ld_st) begin
            sh_deal <= pay[1];
            sh_fin  <= pay[0];
         end
         if (ld_c0) sh_c0 <= pay;
         if (ld_c1) sh_c1 <= pay;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deal               <= 1'b0;
         dealer_finished    <= 1'b0;
         dealer_card_values <= '0;
         frame_valid        <= 1'b0;
         frame_err          <= 1'b0;
         err_count          <= '0;
      end else begin
         frame_valid <= commit_d;
         frame_err   <= err_d;
         if (commit_d) begin
            deal               <= sh_deal;
            dealer_finished    <= sh_fin;
            dealer_card_values <= {pay, sh_c1, sh_c0};
         end
         if (err_d && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_decoder.sv
// Directed self-checking bench for uart_decoder (TIMEOUT_CYCLES = 16).
// Stimulus is applied on falling edges; outputs are sampled there too.
module tb_uart_decoder;
   import uart_proto_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        deal, dealer_finished;
   card_t [2:0] dealer_card_values;
   logic        frame_valid, frame_err;
   logic [7:0]  err_count;

   int n_chk = 0;
   int n_fail = 0;
   int nfv = 0;
   int nfe = 0;

   uart_decoder_if rx ();

   uart_decoder #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .rx                 (rx),
      .deal               (deal),
      .dealer_finished    (dealer_finished),
      .dealer_card_values (dealer_card_values),
      .frame_valid        (frame_valid),
      .frame_err          (frame_err),
      .err_count          (err_count)
   );

   always #5 clk = ~clk;

   task automatic step(input logic e, input logic [7:0] b);
      @(negedge clk);
      if (frame_valid === 1'b1) nfv++;
      if (frame_err === 1'b1) nfe++;
      rx.rx_empty = e;
      rx.r_data   = b;
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b0, b);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 8'h00);
   endtask

   task automatic chk_out(input string nm, input logic d, input logic f,
                          input logic [3:0] c0, input logic [3:0] c1,
                          input logic [3:0] c2);
      n_chk++;
      if ({deal, dealer_finished, dealer_card_values[0],
           dealer_card_values[1], dealer_card_values[2]} !==
          {d, f, c0, c1, c2}) begin
         n_fail++;
         $display("FAIL %s: got d=%b f=%b c=%h,%h,%h want d=%b f=%b c=%h,%h,%h",
                  nm, deal, dealer_finished, dealer_card_values[0],
                  dealer_card_values[1], dealer_card_values[2],
                  d, f, c0, c1, c2);
      end
   endtask

   task automatic chk_cnt(input string nm, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rx.rx_empty = 1'b1;
      rx.r_data = 8'h00;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      nfv = 0;
      nfe = 0;
   endtask

   task automatic test_reset();
      do_reset();
      chk_out("reset_outs", 0, 0, 4'h0, 4'h0, 4'h0);
      chk_cnt("reset_errcnt", int'(err_count), 0);
      chk_cnt("reset_pulses", int'({frame_valid, frame_err}), 0);
      chk_cnt("rd_idle", int'(rx.rd_uart), 0);
      send(8'h20);
      #1;
      chk_cnt("rd_byte", int'(rx.rd_uart), 1);
      idle(1);
   endtask

   task automatic test_basic();
      do_reset();
      send(8'h20); send(8'h51); send(8'hA2); send(8'h33);
      idle(1);
      chk_cnt("basic_fv_hi", int'(frame_valid), 1);
      chk_out("basic_outs", 1, 0, 4'h5, 4'hA, 4'h3);
      idle(1);
      chk_cnt("basic_fv_lo", int'(frame_valid), 0);
      chk_cnt("basic_errcnt", int'(err_count), 0);
   endtask

   task automatic test_hunt_discard();
      nfv = 0; nfe = 0;
      send(8'h51); send(8'h62);
      send(8'h10); send(8'h21); send(8'h42); send(8'h83);
      idle(2);
      chk_cnt("hunt_nfe", nfe, 0);
      chk_cnt("hunt_nfv", nfv, 1);
      chk_out("hunt_outs", 0, 1, 4'h2, 4'h4, 4'h8);
   endtask

   task automatic test_out_of_order();
      do_reset();
      send(8'h20); send(8'h51); send(8'hA2); send(8'h33);
      send(8'h20); send(8'h51); send(8'h33);
      idle(1);
      chk_cnt("ooo_fe_hi", int'(frame_err), 1);
      idle(1);
      chk_cnt("ooo_fe_lo", int'(frame_err), 0);
      chk_cnt("ooo_errcnt", int'(err_count), 1);
      chk_out("ooo_hold", 1, 0, 4'h5, 4'hA, 4'h3);
      nfv = 0; nfe = 0;
      send(8'h10); send(8'hC1); send(8'hD2); send(8'hE3);
      idle(2);
      chk_cnt("ooo_next_nfv", nfv, 1);
      chk_cnt("ooo_next_nfe", nfe, 0);
      chk_out("ooo_next", 0, 1, 4'hC, 4'hD, 4'hE);
   endtask

   task automatic test_timeout();
      do_reset();
      send(8'h20); send(8'h51);
      idle(15);
      send(8'hA2); send(8'h33);
      idle(2);
      chk_cnt("tmo_edge_nfe", nfe, 0);
      chk_cnt("tmo_edge_nfv", nfv, 1);
      chk_out("tmo_edge_outs", 1, 0, 4'h5, 4'hA, 4'h3);
      nfv = 0; nfe = 0;
      send(8'h10); send(8'h71);
      idle(16);
      send(8'hA2); send(8'h33);
      idle(2);
      chk_cnt("tmo_nfe", nfe, 1);
      chk_cnt("tmo_nfv", nfv, 0);
      chk_cnt("tmo_errcnt", int'(err_count), 1);
      chk_out("tmo_hold", 1, 0, 4'h5, 4'hA, 4'h3);
   endtask

   task automatic test_interrupt();
      do_reset();
      send(8'h20); send(8'h51);
      send(8'h10); send(8'h71); send(8'h82); send(8'h93);
      idle(2);
      chk_cnt("int_nfe", nfe, 1);
      chk_cnt("int_nfv", nfv, 1);
      chk_cnt("int_errcnt", int'(err_count), 1);
      chk_out("int_outs", 0, 1, 4'h7, 4'h8, 4'h9);
   endtask

   task automatic test_bad_bytes();
      do_reset();
      send(8'h45);
      send(8'h40);
      idle(2);
      chk_cnt("bad_nfe", nfe, 2);
      chk_cnt("bad_errcnt", int'(err_count), 2);
      repeat (300) send(8'hF4);
      idle(2);
      chk_cnt("sat_nfe", nfe, 302);
      chk_cnt("sat_errcnt", int'(err_count), 255);
   endtask

   task automatic test_reset_midframe();
      do_reset();
      send(8'h20); send(8'h51); send(8'hA2); send(8'h33);
      send(8'h20); send(8'h51);
      @(negedge clk);
      rx.rx_empty = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_out("mid_rst_outs", 0, 0, 4'h0, 4'h0, 4'h0);
      chk_cnt("mid_rst_fv", int'(frame_valid), 0);
      idle(1);
      rst_n = 1'b1;
      nfv = 0; nfe = 0;
      send(8'h62); send(8'h73);
      idle(2);
      chk_cnt("mid_nfv", nfv, 0);
      chk_cnt("mid_nfe", nfe, 0);
      chk_cnt("mid_errcnt", int'(err_count), 0);
      chk_out("mid_outs", 0, 0, 4'h0, 4'h0, 4'h0);
   endtask

   initial begin
      rx.rx_empty = 1'b1;
      rx.r_data   = 8'h00;
      test_reset();
      test_basic();
      test_hunt_discard();
      test_out_of_order();
      test_timeout();
      test_interrupt();
      test_bad_bytes();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_decoder.md
# uart_decoder

Receive-side counterpart of the blackjack UART link. Drains bytes from the UART receiver FIFO and parses the 4-byte status/card frame: status byte (tag 0), then dealer cards 0..2 (tags 1..3). Each complete, in-order frame is committed atomically to registered outputs that drive the remote player's game logic. Malformed, out-of-order or stalled frames are dropped, counted, and the parser resynchronises on the next status byte.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles allowed between bytes of one frame before it is abandoned; must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rx_empty  in  1  receiver FIFO empty
- r_data  in  8  FIFO head byte; first-word-fall-through, valid whenever rx_empty=0
- rd_uart  out  1  pop strobe; FIFO advances at the edge where it is high
- deal  out  1  remote deal flag from the last committed frame
- dealer_finished  out  1  remote dealer-finished flag from the last committed frame
- dealer_card_values  out  3×4  remote dealer cards 0..2 from the last committed frame
- frame_valid  out  1  one-cycle pulse on commit
- frame_err  out  1  one-cycle pulse on any dropped frame or bad byte
- err_count  out  8  saturating error counter

## Operation
- Byte format: r_data[3:0] = tag; r_data[7:4] = payload.
  - Tag 0 payload: {0, 0, deal, dealer_finished}.
  - Tags 1..3 payload: card value for index tag−1.
- rd_uart = ~rx_empty (combinational). Every byte presented is consumed in the same cycle, so throughput is 1 byte/cycle. The parser acts on r_data in every cycle where rd_uart=1.
- FSM states: HUNT, EXP1, EXP2, EXP3.
  - Tag 0 with payload[3:2]=00: latch status into shadow; go to EXP1. If tag 0 arrives in EXP1..EXP3, the old frame is abandoned (frame_err) and the new frame starts; the state is still EXP1.
  - Tag 0 with payload[3:2]≠00: frame_err; go to HUNT.
  - Tag k (1..3) in state EXPk: store card[k−1] in shadow. EXP1→EXP2, EXP2→EXP3. EXP3→HUNT with commit.
  - Tag 1..3 in HUNT: silently discarded. No error, because this is normal after reset or resync.
  - Tag 1..3 in the wrong EXP state, or any tag ≥4 in any state: frame_err; go to HUNT.
- Commit: deal, dealer_finished and dealer_card_values[0..2] are loaded from the shadow registers plus the tag-3 byte in one edge. Outputs never show a partial frame.
- Timeout: an idle counter runs in EXP1..EXP3, cleared by every consumed byte. When it reaches TIMEOUT_CYCLES−1 with no byte present: frame_err; go to HUNT. The counter is held at 0 in HUNT.
- err_count increments on each frame_err pulse and saturates at 255.

## Timing
- Reset values: all outputs 0, state HUNT, shadow 0, idle counter 0. Reset asserted mid-frame discards the shadow and clears the committed outputs.
- Tag-3 byte consumed in cycle n: outputs updated and frame_valid=1 in cycle n+1 only.
- Error detected on a byte in cycle n: frame_err=1 in cycle n+1 only. The committed outputs keep their previous values.
- Tag 0 interrupting a frame: frame_err pulses once, and the new frame proceeds normally.
- A byte and the timeout threshold in the same cycle: the byte wins. It is processed and the counter clears, with no timeout error.
- At most one frame_err pulse per cycle.

## Structure
- Shared package uart_proto_pkg holds:
  - TAG_STATUS=4'd0, TAG_CARD0..2=4'd1..3
  - the card-value width (4)
  - the decoder state enum
- The encoder imports the same tag constants.
- One sub-module, uart_rx_timeout: idle counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Reset, then bytes 0x20, 0x51, 0xA2, 0x33 back-to-back → frame_valid for one cycle after 0x33; deal=1, dealer_finished=0, cards={5, A, 3}; err_count=0.
- Bytes 0x51, 0x62 in HUNT, then a full frame 0x10, 0x21, 0x42, 0x83 → no frame_err; commit with dealer_finished=1, cards={2, 4, 8}.
- Frame 0x20, 0x51, then 0x33 → frame_err, err_count=1, outputs unchanged; a following valid frame commits normally.
- 0x20, 0x51, stall TIMEOUT_CYCLES (set to 16), then 0xA2, 0x33 → frame_err at timeout; no commit; err_count=1.
- 0x20, 0x51, then 0x10, 0x71, 0x82, 0x93 → one frame_err; commit with deal=0, dealer_finished=1, cards={7, 8, 9}.
- Assert rst_n low after 0x20, 0x51 of a frame following an earlier commit → all outputs return to 0 immediately; 0x62, 0x73 after release → no commit, no error.
